// File: rtl/sf_tester_fsm_pkg.sv
// Shared types and constants for the SF Tester write/read-back path.
package sf_tester_fsm_pkg;

    localparam int unsigned c_pattern_w = 8;

    // Start/increment pairs used by the tester when writing and verifying flash.
    localparam logic [c_pattern_w-1:0] c_tester_pattern_startval_a = 8'h00;
    localparam logic [c_pattern_w-1:0] c_tester_pattern_incrval_a  = 8'h01;
    localparam logic [c_pattern_w-1:0] c_tester_pattern_startval_b = 8'h08;
    localparam logic [c_pattern_w-1:0] c_tester_pattern_incrval_b  = 8'h07;
    localparam logic [c_pattern_w-1:0] c_tester_pattern_startval_c = 8'h10;
    localparam logic [c_pattern_w-1:0] c_tester_pattern_incrval_c  = 8'h0F;
    localparam logic [c_pattern_w-1:0] c_tester_pattern_startval_d = 8'h18;
    localparam logic [c_pattern_w-1:0] c_tester_pattern_incrval_d  = 8'h17;

    localparam int unsigned c_per_iteration_byte_count = 256;

    // Read-back checker states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } t_checker_state;

endpackage

// File: rtl/sf_pattern_gen.sv
// Start/increment byte pattern generator; value is registered and wraps mod 256.
module sf_pattern_gen
    import sf_tester_fsm_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   advance,
    input  logic [c_pattern_w-1:0] start_val,
    input  logic [c_pattern_w-1:0] incr_val,
    output logic [c_pattern_w-1:0] value
);

    logic [c_pattern_w-1:0] incr_q;

    // Load has priority so a new iteration always starts from a clean pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value  <= '0;
            incr_q <= '0;
        end else if (load) begin
            value  <= start_val;
            incr_q <= incr_val;
        end else if (advance) begin
            value  <= value + incr_q;
        end
    end

endmodule

// File: rtl/sf_tester_pattern_checker.sv
// Read-back verifier: compares the flash read stream against the written pattern.
module sf_tester_pattern_checker
    import sf_tester_fsm_pkg::*;
#(
    parameter int unsigned BYTE_CNT_W = 32,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                  i_clk_40mhz,
    input  logic                  i_rst_40mhz,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [BYTE_CNT_W-1:0] i_start_addr,
    input  logic [BYTE_CNT_W-1:0] i_byte_count,
    input  logic [7:0]            i_pattern_start,
    input  logic [7:0]            i_pattern_incr,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    output logic                  o_rx_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [ERR_CNT_W-1:0]  o_err_count,
    output logic [BYTE_CNT_W-1:0] o_bytes_checked,
    output logic [BYTE_CNT_W-1:0] o_first_err_addr,
    output logic [7:0]            o_first_err_exp,
    output logic [7:0]            o_first_err_act,
    output logic                  o_unexpected
);

    t_checker_state        state_q;
    t_checker_state        state_d;
    logic [BYTE_CNT_W-1:0] count_q;
    logic [BYTE_CNT_W-1:0] addr_q;
    logic                  first_seen_q;
    logic [7:0]            exp_byte;
    logic                  start_c;
    logic                  accept_c;
    logic                  last_c;
    logic                  mismatch_c;

    // Abort wins over a same-cycle accept, so the byte is dropped uncounted.
    assign start_c    = (state_q == ST_IDLE) && i_start;
    assign accept_c   = (state_q == ST_CHECK) && i_rx_valid && !i_abort;
    assign last_c     = accept_c && (o_bytes_checked == count_q - BYTE_CNT_W'(1));
    assign mismatch_c = accept_c && (i_rx_data != exp_byte);

    sf_pattern_gen u_pattern_gen (
        .clk       (i_clk_40mhz),
        .rst       (i_rst_40mhz),
        .load      (start_c),
        .advance   (accept_c),
        .start_val (i_pattern_start),
        .incr_val  (i_pattern_incr),
        .value     (exp_byte)
    );

    // State register.
    always_ff @(posedge i_clk_40mhz or posedge i_rst_40mhz) begin
        if (i_rst_40mhz) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an empty iteration skips straight to ST_DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = (i_byte_count == '0) ? ST_DONE : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (last_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake/status outputs registered from the next state so they align with it.
    always_ff @(posedge i_clk_40mhz or posedge i_rst_40mhz) begin
        if (i_rst_40mhz) begin
            o_rx_ready   <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_unexpected <= 1'b0;
        end else begin
            o_rx_ready   <= (state_d == ST_CHECK);
            o_busy       <= (state_d != ST_IDLE);
            o_done       <= (state_d == ST_DONE);
            o_unexpected <= i_rx_valid && (state_q != ST_CHECK);
        end
    end

    // Iteration statistics: cleared on start, updated per accepted byte, frozen otherwise.
    always_ff @(posedge i_clk_40mhz or posedge i_rst_40mhz) begin
        if (i_rst_40mhz) begin
            count_q          <= '0;
            addr_q           <= '0;
            first_seen_q     <= 1'b0;
            o_pass           <= 1'b0;
            o_err_count      <= '0;
            o_bytes_checked  <= '0;
            o_first_err_addr <= '0;
            o_first_err_exp  <= '0;
            o_first_err_act  <= '0;
        end else if (start_c) begin
            count_q          <= i_byte_count;
            addr_q           <= i_start_addr;
            first_seen_q     <= 1'b0;
            o_pass           <= (i_byte_count == '0);
            o_err_count      <= '0;
            o_bytes_checked  <= '0;
            o_first_err_addr <= '0;
            o_first_err_exp  <= '0;
            o_first_err_act  <= '0;
        end else if (accept_c) begin
            addr_q          <= addr_q + BYTE_CNT_W'(1);
            o_bytes_checked <= o_bytes_checked + BYTE_CNT_W'(1);
            if (mismatch_c) begin
                if (o_err_count != '1) begin
                    o_err_count <= o_err_count + ERR_CNT_W'(1);
                end
                if (!first_seen_q) begin
                    first_seen_q     <= 1'b1;
                    o_first_err_addr <= addr_q;
                    o_first_err_exp  <= exp_byte;
                    o_first_err_act  <= i_rx_data;
                end
            end
            if (last_c) begin
                o_pass <= (o_err_count == '0) && !mismatch_c;
            end
        end
    end

endmodule
